mmio_arbiter: RTL and testbench



---
 rtl/mmio_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mmio_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// mmio_arbiter
//   Two-master round-robin arbiter in front of the MMIO bus. Master 0 (core)
//   and master 1 (debug/DMA) each issue single-beat read/write requests. A
//   grant runs exactly one transaction through IDLE -> BUS -> DONE. Ties are
//   broken in favour of the master that was not granted last.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   mX_req/wr/addr/wr_data: master X command, held stable until mX_ack
//   mX_ack                : one-cycle completion pulse to master X
//   mX_rd_data            : master X read data, held until its next read
//   mmio_cs/wr/rd         : registered bus strobes, high only in BUS
//   mmio_addr/wr_data     : registered bus address / write data, 0 outside BUS
//   mmio_rd_data          : bus read data, valid in the same cycle as mmio_rd
//   busy                  : high whenever the arbiter is not idle
//   grant_id              : owner of the current or last transaction
module mmio_arbiter #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d;
  logic [DATA_W-1:0] m1_rd_data_q, m1_rd_data_d;
  logic              mmio_cs_q, mmio_cs_d;
  logic              mmio_wr_q, mmio_wr_d;
  logic              mmio_rd_q, mmio_rd_d;
  logic [ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
  logic [DATA_W-1:0] mmio_wr_data_q, mmio_wr_data_d;
  logic              sel;

  // The bus output flops are loaded with the selected command on the
  // IDLE->BUS transition, so they double as the command registers and are
  // cleared again for every other cycle.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_rd_data_d   = m0_rd_data_q;
    m1_rd_data_d   = m1_rd_data_q;
    mmio_cs_d      = 1'b0;
    mmio_wr_d      = 1'b0;
    mmio_rd_d      = 1'b0;
    mmio_addr_d    = '0;
    mmio_wr_data_d = '0;
    sel            = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master not granted last wins; otherwise the sole requester.
          sel            = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          grant_id_d     = sel;
          mmio_cs_d      = 1'b1;
          mmio_wr_d      = sel ? m1_wr : m0_wr;
          mmio_rd_d      = sel ? ~m1_wr : ~m0_wr;
          mmio_addr_d    = sel ? m1_addr : m0_addr;
          mmio_wr_data_d = sel ? m1_wr_data : m0_wr_data;
          state_d        = BUS;
        end
      end
      BUS: begin
        if (mmio_rd_q) begin
          if (grant_id_q) begin
            m1_rd_data_d = mmio_rd_data;
          end else begin
            m0_rd_data_d = mmio_rd_data;
          end
        end
        m0_ack_d = ~grant_id_q;
        m1_ack_d = grant_id_q;
        state_d  = DONE;
      end
      DONE: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_id_q     <= 1'b0;
      last_grant_q   <= 1'b1;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_rd_data_q   <= '0;
      m1_rd_data_q   <= '0;
      mmio_cs_q      <= 1'b0;
      mmio_wr_q      <= 1'b0;
      mmio_rd_q      <= 1'b0;
      mmio_addr_q    <= '0;
      mmio_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_rd_data_q   <= m0_rd_data_d;
      m1_rd_data_q   <= m1_rd_data_d;
      mmio_cs_q      <= mmio_cs_d;
      mmio_wr_q      <= mmio_wr_d;
      mmio_rd_q      <= mmio_rd_d;
      mmio_addr_q    <= mmio_addr_d;
      mmio_wr_data_q <= mmio_wr_data_d;
    end
  end

  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_rd_data   = m0_rd_data_q;
  assign m1_rd_data   = m1_rd_data_q;
  assign mmio_cs      = mmio_cs_q;
  assign mmio_wr      = mmio_wr_q;
  assign mmio_rd      = mmio_rd_q;
  assign mmio_addr    = mmio_addr_q;
  assign mmio_wr_data = mmio_wr_data_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter
//   Scoreboard bench for mmio_arbiter. Drivers push each command into a
//   per-master queue when they raise req; a negedge monitor walks a cycle
//   model of the arbiter, pops the owner's entry on every bus cycle and checks
//   strobes, acks, read data, busy and grant_id against it.
module tb_mmio_arbiter;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [20:0] m0_addr = '0;
  logic [31:0] m0_wr_data = '0;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [20:0] m1_addr = '0;
  logic [31:0] m1_wr_data = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data;
  logic        busy, grant_id;

  int n_chk = 0;
  int n_fail = 0;

  txn_t q0[$];
  txn_t q1[$];
  logic glog[$];

  logic        rst_seen = 1'b1;
  int          mdl_state = 0;
  logic        mdl_gid = 1'b0;
  logic        mdl_last = 1'b1;
  logic [31:0] mdl_rd0 = '0;
  logic [31:0] mdl_rd1 = '0;

  mmio_arbiter #(.ADDR_W(21), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bus_fn(input logic [20:0] a);
    return (a == 21'h000C1) ? 32'hDEADBEEF : {11'h5A5, a};
  endfunction

  // Bus slave: data only meaningful while mmio_rd is high.
  assign mmio_rd_data = mmio_rd ? bus_fn(mmio_addr) : 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    txn_t t;
    if (rst_seen) begin
      mdl_state = 0;
      mdl_gid   = 1'b0;
      mdl_last  = 1'b1;
      mdl_rd0   = '0;
      mdl_rd1   = '0;
    end
    chk("busy", busy, mdl_state != 0);
    chk("grant_id", grant_id, mdl_gid);
    chk("m0_ack", m0_ack, (mdl_state == 2) && !mdl_gid);
    chk("m1_ack", m1_ack, (mdl_state == 2) && mdl_gid);
    chk("m0_rd_data", m0_rd_data, mdl_rd0);
    chk("m1_rd_data", m1_rd_data, mdl_rd1);
    if (mdl_state == 1) begin
      chk("bus_cs", mmio_cs, 1);
      chk("sb_pending", (mdl_gid ? q1.size() : q0.size()) != 0, 1);
      if ((mdl_gid ? q1.size() : q0.size()) != 0) begin
        t = mdl_gid ? q1.pop_front() : q0.pop_front();
        chk("bus_wr", mmio_wr, t.wr);
        chk("bus_rd", mmio_rd, !t.wr);
        chk("bus_addr", mmio_addr, t.addr);
        chk("bus_wr_data", mmio_wr_data, t.wd);
        if (!t.wr) begin
          if (mdl_gid) mdl_rd1 = bus_fn(t.addr);
          else         mdl_rd0 = bus_fn(t.addr);
        end
      end
      glog.push_back(mdl_gid);
      mdl_state = 2;
    end else begin
      chk("bus_quiet", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, '0);
      if (mdl_state == 2) begin
        mdl_last  = mdl_gid;
        mdl_state = 0;
      end else if (m0_req || m1_req) begin
        mdl_gid   = (m0_req && m1_req) ? ~mdl_last : m1_req;
        mdl_state = 1;
      end
    end
  end

  task automatic drive(input logic id, input logic wr, input logic [20:0] addr,
                       input logic [31:0] wd, input logic drop, output int lat);
    int  n;
    logic got;
    @(posedge clk); #1;
    if (id) begin
      m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wr_data = wd;
      q1.push_back('{wr, addr, wd});
    end else begin
      m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wr_data = wd;
      q0.push_back('{wr, addr, wd});
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (id ? m1_ack : m0_ack) got = 1'b1;
    end
    chk("ack_timeout", got, 1);
    lat = n - 1;
    if (drop) begin
      @(posedge clk); #1;
      if (id) m1_req = 1'b0;
      else    m0_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int la, lb;
    logic [3:0] ord;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // m0 read, uncontended
    drive(1'b0, 1'b0, 21'h000C1, 32'h0, 1'b1, la);
    chk("t1_lat", la, 2);
    chk("t1_rd", m0_rd_data, 32'hDEADBEEF);

    // m1 write leaves its read data untouched
    drive(1'b1, 1'b1, 21'h00082, 32'h12345678, 1'b1, lb);
    chk("t2_lat", lb, 2);
    chk("t2_m1_rd", m1_rd_data, 32'h0);

    // simultaneous requests right after reset: m0 first
    do_reset();
    glog.delete();
    fork
      drive(1'b0, 1'b0, 21'h00010, 32'h0, 1'b1, la);
      drive(1'b1, 1'b0, 21'h00020, 32'h0, 1'b1, lb);
    join
    chk("t3_lat0", la, 2);
    chk("t3_lat1", lb, 5);
    chk("t3_n", glog.size(), 2);
    if (glog.size() == 2) chk("t3_order", {glog[0], glog[1]}, 2'b01);

    // continuous requests from both: strict alternation
    do_reset();
    glog.delete();
    fork
      begin
        drive(1'b0, 1'b1, 21'h00100, 32'hA0A0A0A0, 1'b0, la);
        drive(1'b0, 1'b0, 21'h00101, 32'h0, 1'b1, la);
      end
      begin
        drive(1'b1, 1'b1, 21'h00200, 32'hB0B0B0B0, 1'b0, lb);
        drive(1'b1, 1'b0, 21'h00201, 32'h0, 1'b1, lb);
      end
    join
    chk("t4_n", glog.size(), 4);
    if (glog.size() == 4) begin
      ord = '0;
      for (int i = 0; i < 4; i++) ord = {ord[2:0], glog[i]};
      chk("t4_order", ord, 4'b0101);
    end

    // req held past ack starts a new transaction
    drive(1'b0, 1'b1, 21'h00300, 32'h11111111, 1'b0, la);
    chk("t5_lat_a", la, 2);
    drive(1'b0, 1'b1, 21'h00304, 32'h22222222, 1'b1, la);
    chk("t5_lat_b", la, 2);

    // reset during BUS of an m1 read aborts it
    drive(1'b1, 1'b0, 21'h00400, 32'h0, 1'b1, lb);
    chk("t6_pre_rd", m1_rd_data, {11'h5A5, 21'h00400});
    @(posedge clk); #1;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00401; m1_wr_data = 32'h0;
    q1.push_back('{1'b0, 21'h00401, 32'h0});
    @(posedge clk); #1;
    chk("t6_bus_cs", mmio_cs, 1);
    reset = 1'b1; m1_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_no_ack", m1_ack, 0);
    chk("t6_bus_zero", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, '0);
    chk("t6_rd_clr", m1_rd_data, 32'h0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 21'h00402, 32'h0, 1'b1, lb);
    chk("t6_lat", lb, 2);
    chk("t6_rd", m1_rd_data, {11'h5A5, 21'h00402});

    repeat (4) @(posedge clk);
    chk("sb_left", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
